// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: response owner, in-flight tag
// and the helper that retires a tag when its owner flushes.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_tag_t;

    function automatic rsp_tag_t kill_tag(input rsp_tag_t tag,
                                          input logic     kill_if,
                                          input logic     kill_ls);
        rsp_tag_t t;
        t = tag;
        if ((tag.owner == OWN_IF && kill_if) || (tag.owner == OWN_LS && kill_ls))
            t.valid = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_flush;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  ram_rd_data,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport master (
        output if_req, if_addr, if_flush,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output ram_rd_data,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
    );

endinterface

// File: rtl/rsp_tag_pipe.sv
// Shift register of in-flight read tags; the head entry names the owner of
// the RAM read data arriving this cycle. Kills apply as tags shift.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    input  rsp_tag_t push_i,
    input  logic     kill_if_i,
    input  logic     kill_ls_i,
    output rsp_tag_t head_o
);

    rsp_tag_t tags_q [DEPTH];
    rsp_tag_t tags_d [DEPTH];

    // The newly pushed tag bypasses the kill so a read granted in the
    // flush cycle itself survives.
    always_comb begin
        tags_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++)
            tags_d[i] = kill_tag(tags_q[i-1], kill_if_i, kill_ls_i);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: every tag is reset; a stale valid bit would otherwise
            // raise a phantom rvalid after reset.
            for (int i = 0; i < DEPTH; i++)
                tags_q[i] <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign head_o = tags_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the LSU: LSU-first
// priority with a starvation limit, registered commands, tagged responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int STREAK_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TAG_DEPTH = 1 + RD_LATENCY;

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starved;
    logic                if_gnt, ls_gnt;
    logic                issue_rd, issue_wr;
    rsp_tag_t            push_tag, head_tag;
    logic                if_hit, ls_hit;

    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

    // Fetch wins only when it is alone or the LSU has used up its streak.
    always_comb begin
        starved  = bus.if_req && (streak_q == STREAK_W'(STARVE_LIMIT));
        if_gnt   = reset_n && bus.if_req && (!bus.ls_req || starved);
        ls_gnt   = reset_n && bus.ls_req && !starved;
        issue_rd = if_gnt || (ls_gnt && !bus.ls_we);
        issue_wr = ls_gnt && bus.ls_we;
        push_tag = '{valid: issue_rd, owner: (if_gnt ? OWN_IF : OWN_LS)};
    end

    always_comb begin
        // NOTE: default first, so every path assigns streak_d and no latch
        // is inferred.
        streak_d = streak_q;
        if (!bus.if_req || if_gnt)
            streak_d = '0;
        else if (ls_gnt && streak_q != STREAK_W'(STARVE_LIMIT))
            streak_d = streak_q + STREAK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            streak_q <= streak_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_en_q <= issue_rd;
            wr_en_q <= issue_wr;
            if (issue_rd)
                rd_addr_q <= if_gnt ? bus.if_addr : bus.ls_addr;
            if (issue_wr) begin
                wr_addr_q <= bus.ls_addr;
                wr_data_q <= bus.ls_wdata;
            end
        end
    end

    rsp_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (push_tag),
        .kill_if_i (bus.if_flush),
        .kill_ls_i (1'b0),
        .head_o    (head_tag)
    );

    assign if_hit = head_tag.valid && (head_tag.owner == OWN_IF);
    assign ls_hit = head_tag.valid && (head_tag.owner == OWN_LS);

    // Read data passes straight through to the owner; the other side keeps
    // showing its last returned word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_hit) if_rdata_q <= bus.ram_rd_data;
            if (ls_hit) ls_rdata_q <= bus.ram_rd_data;
        end
    end

    assign bus.if_gnt      = if_gnt;
    assign bus.ls_gnt      = ls_gnt;
    assign bus.if_rvalid   = if_hit;
    assign bus.ls_rvalid   = ls_hit;
    assign bus.if_rdata    = if_hit ? bus.ram_rd_data : if_rdata_q;
    assign bus.ls_rdata    = ls_hit ? bus.ram_rd_data : ls_rdata_q;
    assign bus.ram_rd_en   = rd_en_q;
    assign bus.ram_rd_addr = rd_addr_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, each in front of a small RAM model.
module tb_mem_port_arbiter;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rst_n_nxt = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)
    ) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3.slave)
    );

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return 32'hDEADBEEF + a - 32'h10;
    endfunction

    // RAM models: data valid RD_LATENCY cycles after the strobe, garbage otherwise.
    logic        v1;
    logic [31:0] a1;
    logic [2:0]  v3;
    logic [31:0] a3 [3];

    always @(posedge clk) begin
        v1    <= bus1.ram_rd_en;
        a1    <= bus1.ram_rd_addr;
        v3    <= {v3[1:0], bus3.ram_rd_en};
        a3[0] <= bus3.ram_rd_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end

    assign bus1.ram_rd_data = v1    ? ram_val(a1)    : 32'hBAD0_0000;
    assign bus3.ram_rd_data = v3[2] ? ram_val(a3[2]) : 32'hBAD0_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus on the selected instance (1 or 3); the
    // other instance idles. Checks follow 1 time unit after the drive.
    task automatic drive(input int sel,
                         input logic ireq, input logic [31:0] iaddr, input logic ifl,
                         input logic lreq, input logic lwe,
                         input logic [31:0] laddr, input logic [31:0] lwd);
        @(negedge clk);
        reset_n        = rst_n_nxt;
        bus1.if_req    = (sel == 1) && ireq;
        bus1.if_addr   = (sel == 1) ? iaddr : 32'h0;
        bus1.if_flush  = (sel == 1) && ifl;
        bus1.ls_req    = (sel == 1) && lreq;
        bus1.ls_we     = (sel == 1) && lwe;
        bus1.ls_addr   = (sel == 1) ? laddr : 32'h0;
        bus1.ls_wdata  = (sel == 1) ? lwd : 32'h0;
        bus3.if_req    = (sel == 3) && ireq;
        bus3.if_addr   = (sel == 3) ? iaddr : 32'h0;
        bus3.if_flush  = (sel == 3) && ifl;
        bus3.ls_req    = (sel == 3) && lreq;
        bus3.ls_we     = (sel == 3) && lwe;
        bus3.ls_addr   = (sel == 3) ? laddr : 32'h0;
        bus3.ls_wdata  = (sel == 3) ? lwd : 32'h0;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with both requesters active: grants must stay low.
        rst_n_nxt = 1'b0;
        drive(1, 1, 32'h10, 0, 1, 0, 32'h40, 0);
        check("rst_if_gnt", bus1.if_gnt, 0);
        check("rst_ls_gnt", bus1.ls_gnt, 0);
        drive(1, 1, 32'h10, 0, 1, 0, 32'h40, 0);
        check("rst_rd_en",     bus1.ram_rd_en, 0);
        check("rst_wr_en",     bus1.ram_wr_en, 0);
        check("rst_if_rvalid", bus1.if_rvalid, 0);
        check("rst_ls_rvalid", bus1.ls_rvalid, 0);
        check("rst_if_rdata",  bus1.if_rdata, 0);
        check("rst_ls_rdata",  bus1.ls_rdata, 0);
        rst_n_nxt = 1'b1;
        idle();

        // Lone fetch read.
        drive(1, 1, 32'h10, 0, 0, 0, 0, 0);
        check("lf_if_gnt", bus1.if_gnt, 1);
        check("lf_ls_gnt", bus1.ls_gnt, 0);
        idle();
        check("lf_rd_en",     bus1.ram_rd_en, 1);
        check("lf_rd_addr",   bus1.ram_rd_addr, 32'h10);
        check("lf_wr_en",     bus1.ram_wr_en, 0);
        check("lf_early_rv",  bus1.if_rvalid, 0);
        idle();
        check("lf_if_rvalid", bus1.if_rvalid, 1);
        check("lf_if_rdata",  bus1.if_rdata, 32'hDEADBEEF);
        check("lf_ls_rvalid", bus1.ls_rvalid, 0);
        check("lf_rd_en_off", bus1.ram_rd_en, 0);
        idle();
        check("lf_rv_off",    bus1.if_rvalid, 0);
        check("lf_rdata_hold", bus1.if_rdata, 32'hDEADBEEF);

        // LSU write: command next cycle, no response.
        drive(1, 0, 0, 0, 1, 1, 32'h100, 32'h12345678);
        check("wr_ls_gnt", bus1.ls_gnt, 1);
        check("wr_if_gnt", bus1.if_gnt, 0);
        idle();
        check("wr_wr_en",   bus1.ram_wr_en, 1);
        check("wr_wr_addr", bus1.ram_wr_addr, 32'h100);
        check("wr_wr_data", bus1.ram_wr_data, 32'h12345678);
        check("wr_rd_en",   bus1.ram_rd_en, 0);
        idle();
        check("wr_no_rv1",  bus1.ls_rvalid, 0);
        check("wr_wr_off",  bus1.ram_wr_en, 0);
        idle();
        check("wr_no_rv2",  bus1.ls_rvalid, 0);

        // Contention: LS x4 then IF, repeating; responses two cycles later.
        for (int k = 0; k < 12; k++) begin
            logic req;
            req = (k < 10);
            drive(1, req, 32'h300 + 4 * (k / 5), 0,
                     req, 0, 32'h200 + 4 * (k - k / 5), 0);
            if (k < 10) begin
                check($sformatf("ct_if_gnt_%0d", k), bus1.if_gnt, (k % 5 == 4));
                check($sformatf("ct_ls_gnt_%0d", k), bus1.ls_gnt, (k % 5 != 4));
            end
            if (k >= 2) begin
                int g;
                g = k - 2;
                if (g % 5 == 4) begin
                    check($sformatf("ct_if_rv_%0d", g), bus1.if_rvalid, 1);
                    check($sformatf("ct_ls_rv_%0d", g), bus1.ls_rvalid, 0);
                    check($sformatf("ct_if_rd_%0d", g), bus1.if_rdata,
                          ram_val(32'h300 + 4 * (g / 5)));
                end else begin
                    check($sformatf("ct_ls_rv_%0d", g), bus1.ls_rvalid, 1);
                    check($sformatf("ct_if_rv_%0d", g), bus1.if_rvalid, 0);
                    check($sformatf("ct_ls_rd_%0d", g), bus1.ls_rdata,
                          ram_val(32'h200 + 4 * (g - g / 5)));
                end
            end
        end

        // Flush: read granted before the flush dies, read in the flush cycle survives.
        drive(1, 1, 32'h0, 0, 0, 0, 0, 0);
        check("fl_gnt0", bus1.if_gnt, 1);
        drive(1, 1, 32'h4, 1, 0, 0, 0, 0);
        check("fl_gnt4", bus1.if_gnt, 1);
        idle();
        check("fl_killed", bus1.if_rvalid, 0);
        idle();
        check("fl_kept_rv", bus1.if_rvalid, 1);
        check("fl_kept_rd", bus1.if_rdata, ram_val(32'h4));

        // Flush leaves LSU reads alone.
        drive(1, 0, 0, 0, 1, 0, 32'h44, 0);
        check("fl_ls_gnt", bus1.ls_gnt, 1);
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        idle();
        check("fl_ls_rv", bus1.ls_rvalid, 1);
        check("fl_ls_rd", bus1.ls_rdata, ram_val(32'h44));

        // Reset mid-flight with a non-zero streak.
        drive(1, 1, 32'h50, 0, 1, 0, 32'h60, 0);
        check("mr_gnt_a", bus1.ls_gnt, 1);
        drive(1, 1, 32'h50, 0, 1, 0, 32'h64, 0);
        check("mr_gnt_b", bus1.ls_gnt, 1);
        rst_n_nxt = 1'b0;
        drive(1, 1, 32'h50, 0, 1, 0, 32'h68, 0);
        check("mr_rst_ls_gnt", bus1.ls_gnt, 0);
        check("mr_rst_if_gnt", bus1.if_gnt, 0);
        check("mr_rd_en_pre",  bus1.ram_rd_en, 1);
        rst_n_nxt = 1'b1;
        idle();
        check("mr_ls_rvalid", bus1.ls_rvalid, 0);
        check("mr_if_rvalid", bus1.if_rvalid, 0);
        check("mr_rd_en",     bus1.ram_rd_en, 0);
        check("mr_rd_addr",   bus1.ram_rd_addr, 0);
        check("mr_wr_en",     bus1.ram_wr_en, 0);
        check("mr_wr_addr",   bus1.ram_wr_addr, 0);
        check("mr_wr_data",   bus1.ram_wr_data, 0);
        check("mr_if_rdata",  bus1.if_rdata, 0);
        check("mr_ls_rdata",  bus1.ls_rdata, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 32'h70, 0, 1, 0, 32'h80 + 4 * k, 0);
            check($sformatf("mr_if_gnt_%0d", k), bus1.if_gnt, (k == 4));
            check($sformatf("mr_ls_gnt_%0d", k), bus1.ls_gnt, (k != 4));
        end
        idle();
        idle();

        // RD_LATENCY=3: LS@0x20, IF@0x24, LS@0x28 back-to-back.
        drive(3, 0, 0, 0, 1, 0, 32'h20, 0);
        check("l3_gnt0", bus3.ls_gnt, 1);
        drive(3, 1, 32'h24, 0, 0, 0, 0, 0);
        check("l3_gnt1", bus3.if_gnt, 1);
        check("l3_rd_en", bus3.ram_rd_en, 1);
        check("l3_rd_addr", bus3.ram_rd_addr, 32'h20);
        drive(3, 0, 0, 0, 1, 0, 32'h28, 0);
        check("l3_gnt2", bus3.ls_gnt, 1);
        idle();
        check("l3_none_pre_if", bus3.if_rvalid, 0);
        check("l3_none_pre_ls", bus3.ls_rvalid, 0);
        idle();
        check("l3_r0_ls_rv", bus3.ls_rvalid, 1);
        check("l3_r0_if_rv", bus3.if_rvalid, 0);
        check("l3_r0_data",  bus3.ls_rdata, ram_val(32'h20));
        idle();
        check("l3_r1_if_rv", bus3.if_rvalid, 1);
        check("l3_r1_ls_rv", bus3.ls_rvalid, 0);
        check("l3_r1_data",  bus3.if_rdata, ram_val(32'h24));
        idle();
        check("l3_r2_ls_rv", bus3.ls_rvalid, 1);
        check("l3_r2_if_rv", bus3.if_rvalid, 0);
        check("l3_r2_data",  bus3.ls_rdata, ram_val(32'h28));
        idle();
        check("l3_none_post_if", bus3.if_rvalid, 0);
        check("l3_none_post_ls", bus3.ls_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
